// File: rtl/gate_sweep_checker.sv
// rtl/gate_sweep_checker.sv - exhaustive N-input gate sweep with compare, error count and pass flag
// Optional macro GATE_SWEEP_STOP_ON_ERR_EN: end the sweep at the first mismatch.
module gate_sweep_checker #(
  parameter int N    = 2,
  parameter int HOLD = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_x,
  output logic [N-1:0] vec_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_err_vec
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [N-1:0] VEC_MAX  = {N{1'b1}};
  localparam logic [N:0]   ERR_MAX  = {1'b1, {N{1'b0}}};
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_FINISH} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [N:0]    err_q, err_d;
  logic [N-1:0]  first_q, first_d;
  logic          ref_bit;
  logic          mismatch;
  logic          stop_now;

  always_comb begin
    ref_bit = 1'b0;
    case (mode_q)
      2'd0:    ref_bit = &vec_q;
      2'd1:    ref_bit = |vec_q;
      2'd2:    ref_bit = ^vec_q;
      default: ref_bit = ~&vec_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    first_d  = first_q;
    mismatch = 1'b0;
    stop_now = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          mode_d  = mode;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          hold_d  = '0;
        end
      end
      S_DRIVE: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HW'(1);
        end else begin
          hold_d   = '0;
          mismatch = (dut_x != ref_bit);
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d = err_q + (N+1)'(1);
            if (err_q == '0) first_d = vec_q;
          end
`ifdef GATE_SWEEP_STOP_ON_ERR_EN
          stop_now = (vec_q == VEC_MAX) || mismatch;
`else
          stop_now = (vec_q == VEC_MAX);
`endif
          if (stop_now) begin
            state_d = S_FINISH;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
    busy_d = (state_d == S_DRIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      hold_q  <= '0;
      mode_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign vec_out       = vec_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;

endmodule
